// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives the instruction ROM address and the F/D latch,
// and handles stalls, redirects and post-redirect squash bubbles. Define FETCH_PERF_EN for fetch/stall counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC      = 32'd0,
   parameter int          ADDR_W        = 12,
   parameter int          SQUASH_CYCLES = 1,
   parameter logic [31:0] NOP           = 32'd0
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [31:0]       i_redirect_pc,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic [31:0]       i_imem_data,
   output logic [31:0]       o_pc_f,
   output logic [31:0]       o_ir_d,
   output logic [31:0]       o_pc_d,
`ifdef FETCH_PERF_EN
   output logic              o_fd_valid,
   output logic [31:0]       o_fetch_cnt,
   output logic [31:0]       o_stall_cnt
`else
   output logic              o_fd_valid
`endif
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STALLED = 2'd1,
      SQUASH  = 2'd2
   } state_t;

   localparam logic [3:0] SQUASH_LOAD = 4'(SQUASH_CYCLES);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_pc_d;
   logic        r_valid;
   logic [3:0]  r_squash_cnt;

   logic [31:0] w_pc_inc;
   logic        w_fetch;

   assign w_pc_inc = r_pc + 32'd1;
   // A real instruction is latched only outside squash, with no redirect or stall this edge.
   assign w_fetch  = !i_redirect && !i_stall && (r_state != SQUASH);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= RUN;
         r_pc         <= RESET_PC;
         r_ir         <= NOP;
         r_pc_d       <= 32'd0;
         r_valid      <= 1'b0;
         r_squash_cnt <= 4'd0;
      end else if (i_redirect) begin
         r_pc         <= i_redirect_pc;
         r_ir         <= NOP;
         r_valid      <= 1'b0;
         r_squash_cnt <= SQUASH_LOAD;
         r_state      <= (SQUASH_LOAD != 4'd0) ? SQUASH : RUN;
      end else begin
         case (r_state)
            RUN: begin
               if (i_stall) r_state <= STALLED;
            end
            STALLED: begin
               if (!i_stall) r_state <= RUN;
            end
            SQUASH: begin
               // PC keeps advancing but the fetched word is thrown away.
               if (!i_stall) begin
                  r_pc         <= w_pc_inc;
                  r_ir         <= NOP;
                  r_pc_d       <= w_pc_inc;
                  r_valid      <= 1'b0;
                  r_squash_cnt <= r_squash_cnt - 4'd1;
                  if (r_squash_cnt <= 4'd1) r_state <= RUN;
               end
            end
            default: r_state <= RUN;
         endcase
         if (w_fetch) begin
            r_pc    <= w_pc_inc;
            r_ir    <= i_imem_data;
            r_pc_d  <= w_pc_inc;
            r_valid <= 1'b1;
         end
      end
   end

   assign o_imem_addr = r_pc[ADDR_W-1:0];
   assign o_pc_f      = r_pc;
   assign o_ir_d      = r_ir;
   assign o_pc_d      = r_pc_d;
   assign o_fd_valid  = r_valid;

`ifdef FETCH_PERF_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_fetch_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (w_fetch) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (i_stall && !i_redirect) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign o_fetch_cnt = r_fetch_cnt;
   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect
// traffic checked against a behavioural model of the fetch pipeline.
module tb_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'd0;
   localparam int          ADDR_W   = 12;
   localparam int          SQ       = 1;
   localparam logic [31:0] NOP      = 32'd0;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic              redirect;
   logic [31:0]       rpc;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic [31:0]       pc_f;
   logic [31:0]       ir_d;
   logic [31:0]       pc_d;
   logic              fd_valid;
`ifdef FETCH_PERF_EN
   logic [31:0]       fetch_cnt;
   logic [31:0]       stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // behavioural model state
   logic [31:0] m_pc, m_ir, m_pcd;
   logic        m_pcd_known, m_valid;
   int          m_sq;
   logic [31:0] m_fcnt, m_scnt;

   fetch_stage #(
      .RESET_PC(RESET_PC), .ADDR_W(ADDR_W), .SQUASH_CYCLES(SQ), .NOP(NOP)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .i_stall(stall),
      .i_redirect(redirect),
      .i_redirect_pc(rpc),
      .o_imem_addr(imem_addr),
      .i_imem_data(imem_data),
      .o_pc_f(pc_f),
      .o_ir_d(ir_d),
      .o_pc_d(pc_d),
`ifdef FETCH_PERF_EN
      .o_fd_valid(fd_valid),
      .o_fetch_cnt(fetch_cnt),
      .o_stall_cnt(stall_cnt)
`else
      .o_fd_valid(fd_valid)
`endif
   );

   always #5 clk = ~clk;

   // ROM[i] = i + 100
   assign imem_data = 32'(imem_addr) + 32'd100;

   function automatic logic [31:0] rom_of(input logic [31:0] pc);
      logic [ADDR_W-1:0] a;
      a = pc[ADDR_W-1:0];
      return 32'(a) + 32'd100;
   endfunction

   task automatic model_reset();
      m_pc = RESET_PC; m_ir = NOP; m_pcd = 32'd0; m_pcd_known = 1'b1;
      m_valid = 1'b0; m_sq = 0; m_fcnt = 32'd0; m_scnt = 32'd0;
   endtask

   // Apply one cycle of inputs, advance the model across the edge, sample 1ns later.
   task automatic step(input logic s, input logic r, input logic [31:0] p);
      stall = s; redirect = r; rpc = p;
      @(posedge clk);
      if (r) begin
         m_pc = p; m_ir = NOP; m_valid = 1'b0; m_pcd_known = 1'b0; m_sq = SQ;
      end else if (s) begin
         m_scnt = m_scnt + 32'd1;
      end else if (m_sq > 0) begin
         m_ir = NOP; m_pcd = m_pc + 32'd1; m_pcd_known = 1'b1; m_valid = 1'b0;
         m_pc = m_pc + 32'd1; m_sq = m_sq - 1;
      end else begin
         m_ir = rom_of(m_pc); m_pcd = m_pc + 32'd1; m_pcd_known = 1'b1; m_valid = 1'b1;
         m_pc = m_pc + 32'd1; m_fcnt = m_fcnt + 32'd1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = 32'd0;
      model_reset();
      #1;
      total++; if (pc_f !== RESET_PC) begin bad++; $display("FAIL reset_pc_f got=%h want=%h", pc_f, RESET_PC); end
      total++; if (ir_d !== NOP) begin bad++; $display("FAIL reset_ir_d got=%h want=%h", ir_d, NOP); end
      total++; if (pc_d !== 32'd0) begin bad++; $display("FAIL reset_pc_d got=%h want=0", pc_d); end
      total++; if (fd_valid !== 1'b0) begin bad++; $display("FAIL reset_fd_valid got=%b want=0", fd_valid); end
      total++; if (imem_addr !== RESET_PC[ADDR_W-1:0]) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC[ADDR_W-1:0]); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
   endtask

   task automatic test_free_run();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 32'd0);
         total++; if (ir_d !== 32'(100 + i)) begin bad++; $display("FAIL free_run_ir_d[%0d] got=%0d want=%0d", i, ir_d, 100 + i); end
         total++; if (pc_d !== 32'(i + 1)) begin bad++; $display("FAIL free_run_pc_d[%0d] got=%0d want=%0d", i, pc_d, i + 1); end
         total++; if (fd_valid !== 1'b1) begin bad++; $display("FAIL free_run_valid[%0d] got=%b want=1", i, fd_valid); end
      end
      total++; if (pc_f !== 32'd4) begin bad++; $display("FAIL free_run_pc_f got=%0d want=4", pc_f); end
   endtask

   task automatic test_stall();
      step(1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 32'd0);
         total++; if (pc_f !== 32'd5) begin bad++; $display("FAIL stall_pc_f[%0d] got=%0d want=5", k, pc_f); end
         total++; if (ir_d !== 32'd104) begin bad++; $display("FAIL stall_ir_d[%0d] got=%0d want=104", k, ir_d); end
         total++; if (pc_d !== 32'd5) begin bad++; $display("FAIL stall_pc_d[%0d] got=%0d want=5", k, pc_d); end
      end
      step(1'b0, 1'b0, 32'd0);
      total++; if (ir_d !== 32'd105) begin bad++; $display("FAIL stall_release_ir_d got=%0d want=105", ir_d); end
      total++; if (pc_d !== 32'd6) begin bad++; $display("FAIL stall_release_pc_d got=%0d want=6", pc_d); end
      total++; if (pc_f !== 32'd6) begin bad++; $display("FAIL stall_release_pc_f got=%0d want=6", pc_f); end
`ifdef FETCH_PERF_EN
      total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL perf_stall_cnt got=%0d want=3", stall_cnt); end
      total++; if (fetch_cnt !== 32'd6) begin bad++; $display("FAIL perf_fetch_cnt got=%0d want=6", fetch_cnt); end
`endif
   endtask

   task automatic test_redirect();
      repeat (4) step(1'b0, 1'b0, 32'd0);
      total++; if (pc_f !== 32'd10) begin bad++; $display("FAIL redir_setup_pc_f got=%0d want=10", pc_f); end
      step(1'b0, 1'b1, 32'd40);
      total++; if (pc_f !== 32'd40) begin bad++; $display("FAIL redir_pc_f got=%0d want=40", pc_f); end
      total++; if (ir_d !== NOP) begin bad++; $display("FAIL redir_ir_d got=%h want=%h", ir_d, NOP); end
      total++; if (fd_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b want=0", fd_valid); end
      step(1'b0, 1'b0, 32'd0);
      total++; if (pc_f !== 32'd41) begin bad++; $display("FAIL squash_pc_f got=%0d want=41", pc_f); end
      total++; if (fd_valid !== 1'b0) begin bad++; $display("FAIL squash_valid got=%b want=0", fd_valid); end
      total++; if (pc_d !== 32'd41) begin bad++; $display("FAIL squash_pc_d got=%0d want=41", pc_d); end
      step(1'b0, 1'b0, 32'd0);
      total++; if (ir_d !== 32'd141) begin bad++; $display("FAIL post_squash_ir_d got=%0d want=141", ir_d); end
      total++; if (fd_valid !== 1'b1) begin bad++; $display("FAIL post_squash_valid got=%b want=1", fd_valid); end
      total++; if (pc_d !== 32'd42) begin bad++; $display("FAIL post_squash_pc_d got=%0d want=42", pc_d); end
   endtask

   task automatic test_stall_redirect();
      step(1'b1, 1'b1, 32'd7);
      total++; if (pc_f !== 32'd7) begin bad++; $display("FAIL sr_pc_f got=%0d want=7", pc_f); end
      total++; if (fd_valid !== 1'b0) begin bad++; $display("FAIL sr_valid got=%b want=0", fd_valid); end
      total++; if (ir_d !== NOP) begin bad++; $display("FAIL sr_ir_d got=%h want=%h", ir_d, NOP); end
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b0, 32'd0);
         total++; if (pc_f !== 32'd7) begin bad++; $display("FAIL sr_hold_pc_f[%0d] got=%0d want=7", k, pc_f); end
      end
      step(1'b0, 1'b0, 32'd0);
      total++; if (pc_f !== 32'd8 || fd_valid !== 1'b0) begin bad++; $display("FAIL sr_squash got pc_f=%0d valid=%b want pc_f=8 valid=0", pc_f, fd_valid); end
      step(1'b0, 1'b0, 32'd0);
      total++; if (ir_d !== 32'd108 || fd_valid !== 1'b1) begin bad++; $display("FAIL sr_resume got ir_d=%0d valid=%b want ir_d=108 valid=1", ir_d, fd_valid); end
   endtask

   task automatic test_wrap_async_reset();
      step(1'b0, 1'b1, 32'hFFFF_FFFF);
      total++; if (pc_f !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_load_pc_f got=%h want=ffffffff", pc_f); end
      step(1'b0, 1'b0, 32'd0);
      total++; if (pc_f !== 32'd0) begin bad++; $display("FAIL wrap_pc_f got=%h want=0", pc_f); end
      total++; if (pc_d !== 32'd0) begin bad++; $display("FAIL wrap_pc_d got=%h want=0", pc_d); end
      total++; if (imem_addr !== '0) begin bad++; $display("FAIL wrap_addr got=%h want=0", imem_addr); end
      step(1'b0, 1'b0, 32'd0);
      total++; if (ir_d !== 32'd100 || pc_d !== 32'd1) begin bad++; $display("FAIL wrap_fetch got ir_d=%0d pc_d=%0d want 100/1", ir_d, pc_d); end
      // reset pulsed between edges must act without a clock
      @(negedge clk); rst = 1'b1;
      #1;
      model_reset();
      total++; if (pc_f !== RESET_PC) begin bad++; $display("FAIL async_rst_pc_f got=%h want=%h", pc_f, RESET_PC); end
      total++; if (fd_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid got=%b want=0", fd_valid); end
      total++; if (ir_d !== NOP || pc_d !== 32'd0) begin bad++; $display("FAIL async_rst_fd got ir_d=%h pc_d=%h want %h/0", ir_d, pc_d, NOP); end
`ifdef FETCH_PERF_EN
      total++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin bad++; $display("FAIL async_rst_perf got f=%0d s=%0d want 0/0", fetch_cnt, stall_cnt); end
`endif
      #1 rst = 1'b0;
   endtask

   task automatic test_random();
      logic s, r;
      logic [31:0] p;
      for (int i = 0; i < 400; i++) begin
         s = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 7) == 0);
         p = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5000)) : $urandom;
         step(s, r, p);
         total++; if (pc_f !== m_pc) begin bad++; $display("FAIL rand_pc_f[%0d] got=%h want=%h", i, pc_f, m_pc); end
         total++; if (imem_addr !== m_pc[ADDR_W-1:0]) begin bad++; $display("FAIL rand_addr[%0d] got=%h want=%h", i, imem_addr, m_pc[ADDR_W-1:0]); end
         total++; if (ir_d !== m_ir) begin bad++; $display("FAIL rand_ir_d[%0d] got=%h want=%h", i, ir_d, m_ir); end
         total++; if (fd_valid !== m_valid) begin bad++; $display("FAIL rand_valid[%0d] got=%b want=%b", i, fd_valid, m_valid); end
         if (m_pcd_known) begin
            total++; if (pc_d !== m_pcd) begin bad++; $display("FAIL rand_pc_d[%0d] got=%h want=%h", i, pc_d, m_pcd); end
         end
`ifdef FETCH_PERF_EN
         total++; if (fetch_cnt !== m_fcnt) begin bad++; $display("FAIL rand_fetch_cnt[%0d] got=%0d want=%0d", i, fetch_cnt, m_fcnt); end
         total++; if (stall_cnt !== m_scnt) begin bad++; $display("FAIL rand_stall_cnt[%0d] got=%0d want=%0d", i, stall_cnt, m_scnt); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_redirect();
      test_stall_redirect();
      test_wrap_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
